mode_reporter: RTL

//   UART transmitter that sends the current pacing configuration back to the host in the

---
 rtl/mode_reporter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mode_reporter.sv
// Serial reporter: snapshots the pacing configuration and sends it as four 8N1 bytes, LSB first.
// It has its own baud counter and bit serializer, so no external UART core is needed.
module mode_reporter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_BYTES    = 4
) (
    input  logic        clk_fast,
    input  logic        rst_n,
    input  logic        send,
    input  logic [15:0] SA_rest,
    input  logic        pace_en,
    input  logic [15:0] AV_forw,
    input  logic        PACen,
    input  logic        PVCen,
    output logic        tx,
    output logic        busy,
    output logic        tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      byte_q, byte_d;
    logic [31:0]     shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            wrap_s;
    logic            accept_s;
    logic            unused_bits_s;

    assign wrap_s        = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign accept_s      = send & ~busy_q;
    assign unused_bits_s = ^{SA_rest[15], AV_forw[15:14]};

    // State and output registers; reset abandons any frame and idles the line high.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            shift_q <= 32'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: baud counter, bit/byte counters and the frame shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept_s) begin
                    state_d = START;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                    shift_d = {PVCen, PACen, AV_forw[13:0], pace_en, SA_rest[14:0]};
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (wrap_s) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (wrap_s) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[31:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (wrap_s) begin
                    cnt_d  = '0;
                    byte_d = byte_q + 3'd1;
                    if ((byte_q + 3'd1) < 3'(NUM_BYTES)) begin
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic is computed from the next state so tx/busy/tx_done come straight from flops.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && wrap_s && (byte_q == 3'(NUM_BYTES - 1));
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;
endmodule
